// File: rtl/axi4_cacheif_resp.sv
// AXI4 responder: terminates AXI4 read/write bursts as single-beat cacheIf memory requests.
// Latency: write beat to memory in the W handshake cycle; bvalid 1 cycle after wlast; first mem_re 1 cycle after AR.
// Backpressure: wready follows mem_wreq_rdy; mem_re is throttled by read-FIFO credits, so rready stalls never drop data.
//
// Ports: clk/rst (sync, active-high); AXI4 AW/W/B and AR/R slave channels (axi4_*);
// memory write request (mem_bwe/mem_wad/mem_wdat, mem_wreq_rdy); memory read request
// (mem_re/mem_rad, mem_rreq_rdy) and in-order read return (mem_rdat/mem_rdat_vld).
module axi4_cacheif_resp #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int RFIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    // write address
    input  logic            axi4_awvalid,
    output logic            axi4_awready,
    input  logic [AW-1:0]   axi4_awaddr,
    input  logic [7:0]      axi4_awlen,
    input  logic [1:0]      axi4_awburst,
    input  logic [2:0]      axi4_awsize,
    input  logic [7:0]      axi4_awid,
    // write data
    input  logic            axi4_wvalid,
    output logic            axi4_wready,
    input  logic [DW-1:0]   axi4_wdata,
    input  logic [DW/8-1:0] axi4_wstrb,
    input  logic            axi4_wlast,
    // write response
    output logic            axi4_bvalid,
    input  logic            axi4_bready,
    output logic [1:0]      axi4_bresp,
    output logic [7:0]      axi4_bid,
    // read address
    input  logic            axi4_arvalid,
    output logic            axi4_arready,
    input  logic [AW-1:0]   axi4_araddr,
    input  logic [7:0]      axi4_arlen,
    input  logic [1:0]      axi4_arburst,
    input  logic [2:0]      axi4_arsize,
    input  logic [7:0]      axi4_arid,
    // read data
    output logic            axi4_rvalid,
    input  logic            axi4_rready,
    output logic [DW-1:0]   axi4_rdata,
    output logic [1:0]      axi4_rresp,
    output logic            axi4_rlast,
    output logic [7:0]      axi4_rid,
    // memory write port
    output logic [DW/8-1:0] mem_bwe,
    output logic [AW-1:0]   mem_wad,
    output logic [DW-1:0]   mem_wdat,
    input  logic            mem_wreq_rdy,
    // memory read port
    output logic            mem_re,
    output logic [AW-1:0]   mem_rad,
    input  logic            mem_rreq_rdy,
    input  logic [DW-1:0]   mem_rdat,
    input  logic            mem_rdat_vld
);
    localparam int PW = $clog2(RFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0]    BURST_INCR  = 2'b01;
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [AW-1:0] ADDR_STEP   = AW'(DW / 8);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_BURST}        rstate_t;

    // transfer size is always full width
    logic unused_size;
    assign unused_size = ^{axi4_awsize, axi4_arsize};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t       w_state, w_next;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_len, w_cnt, w_id;
    logic [1:0]    w_burst;
    logic          w_over;   // beats beyond awlen: accepted, never written
    logic          w_err;
    logic          w_legal, aw_hs, w_hs, w_mem, w_ready_i;

    assign w_legal   = ~w_burst[1];
    assign aw_hs     = (w_state == W_IDLE) & axi4_awvalid;
    assign w_ready_i = (w_state == W_DATA) & (w_legal ? mem_wreq_rdy : 1'b1);
    assign w_hs      = w_ready_i & axi4_wvalid;
    assign w_mem     = w_hs & w_legal & ~w_over;

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (axi4_awvalid)          w_next = W_DATA;
            W_DATA:  if (w_hs && axi4_wlast)    w_next = W_RESP;
            W_RESP:  if (axi4_bready)           w_next = W_IDLE;
            default:                            w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_id    <= '0;
            w_burst <= '0;
            w_over  <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= axi4_awaddr;
            w_len   <= axi4_awlen;
            w_burst <= axi4_awburst;
            w_id    <= axi4_awid;
            w_cnt   <= '0;
            w_over  <= 1'b0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            if (w_burst == BURST_INCR) w_addr <= w_addr + ADDR_STEP;
            if (!w_over) begin
                if (w_cnt == w_len) begin
                    // last expected beat without wlast: the burst runs long
                    if (!axi4_wlast) begin
                        w_over <= 1'b1;
                        w_err  <= 1'b1;
                    end
                end else begin
                    w_cnt <= w_cnt + 8'd1;
                    if (axi4_wlast) w_err <= 1'b1;  // early wlast
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t       r_state, r_next;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_len, r_id, r_pop;
    logic [8:0]    r_issued;
    logic [1:0]    r_burst;
    logic [CW-1:0] credit;   // requests issued but not yet popped from the FIFO
    logic          r_legal, ar_hs, mem_re_i, issue, push, fifo_pop;
    logic          rvalid_i, rlast_i, r_hs;

    logic [DW-1:0] fifo_mem [RFIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;

    assign r_legal  = ~r_burst[1];
    assign ar_hs    = (r_state == R_IDLE) & axi4_arvalid;
    assign mem_re_i = (r_state == R_BURST) & r_legal & (r_issued <= {1'b0, r_len})
                    & (credit < CW'(RFIFO_DEPTH));
    assign issue    = mem_re_i & mem_rreq_rdy;
    // returns outside a burst are stale traffic from before a reset
    assign push     = mem_rdat_vld & (r_state == R_BURST) & r_legal;
    // illegal bursts fabricate zero beats without touching memory
    assign rvalid_i = (r_state == R_BURST) & (r_legal ? (fifo_cnt != '0) : 1'b1);
    assign rlast_i  = (r_state == R_BURST) & (r_pop == r_len);
    assign r_hs     = rvalid_i & axi4_rready;
    assign fifo_pop = r_hs & r_legal;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (axi4_arvalid)     r_next = R_BURST;
            R_BURST: if (r_hs && rlast_i)  r_next = R_IDLE;
            default:                       r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_id     <= '0;
            r_burst  <= '0;
            r_issued <= '0;
            r_pop    <= '0;
        end else if (ar_hs) begin
            r_addr   <= axi4_araddr;
            r_len    <= axi4_arlen;
            r_id     <= axi4_arid;
            r_burst  <= axi4_arburst;
            r_issued <= '0;
            r_pop    <= '0;
        end else begin
            if (issue) begin
                r_issued <= r_issued + 9'd1;
                if (r_burst == BURST_INCR) r_addr <= r_addr + ADDR_STEP;
            end
            if (r_hs) r_pop <= r_pop + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit   <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case ({issue, fifo_pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
            case ({push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push)     wr_ptr <= wr_ptr + PW'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdat;
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_cnt == CW'(RFIFO_DEPTH))));

    // ------------------------------------------------------------------
    // Outputs, forced to zero while reset is asserted
    // ------------------------------------------------------------------
    assign axi4_awready = ~rst & (w_state == W_IDLE);
    assign axi4_wready  = ~rst & w_ready_i;
    assign axi4_bvalid  = ~rst & (w_state == W_RESP);
    assign axi4_bresp   = (rst || w_state != W_RESP) ? RESP_OKAY
                        : ((w_err || !w_legal) ? RESP_SLVERR : RESP_OKAY);
    assign axi4_bid     = rst ? '0 : w_id;

    assign axi4_arready = ~rst & (r_state == R_IDLE);
    assign axi4_rvalid  = ~rst & rvalid_i;
    assign axi4_rdata   = (rst || !rvalid_i || !r_legal) ? '0 : fifo_mem[rd_ptr];
    assign axi4_rresp   = (rst || r_legal) ? RESP_OKAY : RESP_SLVERR;
    assign axi4_rlast   = ~rst & rlast_i;
    assign axi4_rid     = rst ? '0 : r_id;

    assign mem_bwe  = (rst || !w_mem) ? '0 : axi4_wstrb;
    assign mem_wad  = rst ? '0 : w_addr;
    assign mem_wdat = rst ? '0 : axi4_wdata;
    assign mem_re   = ~rst & mem_re_i;
    assign mem_rad  = rst ? '0 : r_addr;

endmodule

// File: tb/tb_axi4_cacheif_resp.sv
module tb_axi4_cacheif_resp;
    localparam int DEPTH = 8;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi4_awvalid, axi4_awready;
    logic [31:0] axi4_awaddr;
    logic [7:0]  axi4_awlen, axi4_awid;
    logic [1:0]  axi4_awburst;
    logic [2:0]  axi4_awsize;
    logic        axi4_wvalid, axi4_wready, axi4_wlast;
    logic [31:0] axi4_wdata;
    logic [3:0]  axi4_wstrb;
    logic        axi4_bvalid, axi4_bready;
    logic [1:0]  axi4_bresp;
    logic [7:0]  axi4_bid;
    logic        axi4_arvalid, axi4_arready;
    logic [31:0] axi4_araddr;
    logic [7:0]  axi4_arlen, axi4_arid;
    logic [1:0]  axi4_arburst;
    logic [2:0]  axi4_arsize;
    logic        axi4_rvalid, axi4_rready, axi4_rlast;
    logic [31:0] axi4_rdata;
    logic [1:0]  axi4_rresp;
    logic [7:0]  axi4_rid;
    logic [3:0]  mem_bwe;
    logic [31:0] mem_wad, mem_wdat, mem_rad, mem_rdat;
    logic        mem_wreq_rdy, mem_re, mem_rreq_rdy, mem_rdat_vld;

    axi4_cacheif_resp #(.DW(32), .AW(32), .RFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .axi4_awvalid(axi4_awvalid), .axi4_awready(axi4_awready), .axi4_awaddr(axi4_awaddr),
        .axi4_awlen(axi4_awlen), .axi4_awburst(axi4_awburst), .axi4_awsize(axi4_awsize),
        .axi4_awid(axi4_awid),
        .axi4_wvalid(axi4_wvalid), .axi4_wready(axi4_wready), .axi4_wdata(axi4_wdata),
        .axi4_wstrb(axi4_wstrb), .axi4_wlast(axi4_wlast),
        .axi4_bvalid(axi4_bvalid), .axi4_bready(axi4_bready), .axi4_bresp(axi4_bresp),
        .axi4_bid(axi4_bid),
        .axi4_arvalid(axi4_arvalid), .axi4_arready(axi4_arready), .axi4_araddr(axi4_araddr),
        .axi4_arlen(axi4_arlen), .axi4_arburst(axi4_arburst), .axi4_arsize(axi4_arsize),
        .axi4_arid(axi4_arid),
        .axi4_rvalid(axi4_rvalid), .axi4_rready(axi4_rready), .axi4_rdata(axi4_rdata),
        .axi4_rresp(axi4_rresp), .axi4_rlast(axi4_rlast), .axi4_rid(axi4_rid),
        .mem_bwe(mem_bwe), .mem_wad(mem_wad), .mem_wdat(mem_wdat), .mem_wreq_rdy(mem_wreq_rdy),
        .mem_re(mem_re), .mem_rad(mem_rad), .mem_rreq_rdy(mem_rreq_rdy),
        .mem_rdat(mem_rdat), .mem_rdat_vld(mem_rdat_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [3:0] s; logic [31:0] d; } wexp_t;
    typedef struct packed { logic [31:0] d; logic [1:0] resp; logic last; logic [7:0] id; } rexp_t;
    typedef struct packed { logic [1:0] resp; logic [7:0] id; } bexp_t;

    wexp_t       exp_w[$];
    logic [31:0] exp_rad[$];
    rexp_t       exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] pend_a[$];
    int          pend_due[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 3;
    int wrdy_mode = 0, rrdy_mode = 0, rready_mode = 0, bready_mode = 0;
    int rready_hold = 0;
    int inflight = 0;
    bit chk_mirror = 1'b0;
    bit stall_prev = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_rlast;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    // memory contents, as seen by reads: a fixed scramble of the address
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] b, input int i);
        return (b == FIXED) ? base : base + 32'(i * 4);
    endfunction

    // ready generators, driven away from the active edge
    always @(posedge clk) begin
        #1;
        cyc++;
        case (wrdy_mode)
            0:       mem_wreq_rdy = 1'b1;
            1:       mem_wreq_rdy = ($urandom_range(0, 1) == 1);
            default: mem_wreq_rdy = ((cyc % 2) == 1);
        endcase
        mem_rreq_rdy = (rrdy_mode == 0) || ($urandom_range(0, 1) == 1);
        axi4_rready  = (cyc >= rready_hold) && ((rready_mode == 0) || ($urandom_range(0, 1) == 1));
        axi4_bready  = (bready_mode == 0) || ($urandom_range(0, 1) == 1);
    end

    // monitor / scoreboard and memory read-return model
    always @(negedge clk) begin
        if (rst) begin
            pend_a.delete();
            pend_due.delete();
            mem_rdat_vld = 1'b0;
            inflight = 0;
            stall_prev = 1'b0;
        end else begin
            if (mem_bwe != 4'h0) begin
                if (exp_w.size() == 0) fail("unexpected_mem_write");
                else begin
                    wexp_t e;
                    e = exp_w.pop_front();
                    chk("mem_wad", 64'(mem_wad), 64'(e.a));
                    chk("mem_bwe", 64'(mem_bwe), 64'(e.s));
                    chk("mem_wdat", 64'(mem_wdat), 64'(e.d));
                end
            end
            if (mem_re && mem_rreq_rdy) begin
                if (exp_rad.size() == 0) fail("unexpected_mem_re");
                else chk("mem_rad", 64'(mem_rad), 64'(exp_rad.pop_front()));
                chk("credit_limit", 64'(inflight < DEPTH), 64'(1));
                inflight++;
                pend_a.push_back(mem_rad);
                pend_due.push_back(cyc + lat);
            end
            if (stall_prev) begin
                chk("rvalid_held", 64'(axi4_rvalid), 64'(1));
                chk("rdata_held", 64'(axi4_rdata), 64'(prev_rdata));
                chk("rlast_held", 64'(axi4_rlast), 64'(prev_rlast));
            end
            if (axi4_rvalid && axi4_rready) begin
                if (exp_r.size() == 0) fail("unexpected_r_beat");
                else begin
                    rexp_t r;
                    r = exp_r.pop_front();
                    chk("rdata", 64'(axi4_rdata), 64'(r.d));
                    chk("rresp", 64'(axi4_rresp), 64'(r.resp));
                    chk("rlast", 64'(axi4_rlast), 64'(r.last));
                    chk("rid", 64'(axi4_rid), 64'(r.id));
                    if (r.resp == 2'b00) inflight--;
                end
            end
            stall_prev = axi4_rvalid && !axi4_rready;
            prev_rdata = axi4_rdata;
            prev_rlast = axi4_rlast;
            if (axi4_bvalid && axi4_bready) begin
                if (exp_b.size() == 0) fail("unexpected_b");
                else begin
                    bexp_t b;
                    b = exp_b.pop_front();
                    chk("bresp", 64'(axi4_bresp), 64'(b.resp));
                    chk("bid", 64'(axi4_bid), 64'(b.id));
                end
            end
            if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
                mem_rdat_vld = 1'b1;
                mem_rdat = rd_fn(pend_a.pop_front());
                pend_due.delete(0);
            end else begin
                mem_rdat_vld = 1'b0;
                mem_rdat = $urandom;
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] id, input int nbeats, input logic [31:0] d0, input bit rnd);
        bit    legal;
        int    n;
        bexp_t be;
        legal = !burst[1];
        be.resp = (legal && nbeats == int'(len) + 1) ? 2'b00 : 2'b10;
        be.id = id;
        exp_b.push_back(be);
        @(posedge clk); #1;
        axi4_awvalid = 1'b1; axi4_awaddr = addr; axi4_awlen = len;
        axi4_awburst = burst; axi4_awid = id; axi4_awsize = 3'($urandom_range(0, 7));
        n = 0;
        forever begin
            @(negedge clk);
            if (axi4_awready) break;
            n++;
            if (n > 500) begin fail("aw_timeout"); break; end
        end
        @(posedge clk); #1;
        axi4_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wexp_t we;
            we.a = beat_addr(addr, burst, i);
            we.d = rnd ? $urandom : d0 + 32'(i);
            we.s = rnd ? (($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15))) : 4'hF;
            if (legal && i <= int'(len) && we.s != 4'h0) exp_w.push_back(we);
            axi4_wvalid = 1'b1; axi4_wdata = we.d; axi4_wstrb = we.s; axi4_wlast = (i == nbeats - 1);
            n = 0;
            forever begin
                @(negedge clk);
                if (chk_mirror) chk("wready_mirrors_wreq_rdy", 64'(axi4_wready), 64'(mem_wreq_rdy));
                if (axi4_wready) break;
                n++;
                if (n > 500) begin fail("w_timeout"); break; end
            end
            @(posedge clk); #1;
        end
        axi4_wvalid = 1'b0; axi4_wlast = 1'b0;
        n = 0;
        forever begin
            @(posedge clk);
            if (exp_b.size() == 0) break;
            n++;
            if (n > 500) begin fail("b_timeout"); exp_b.delete(); break; end
        end
        @(negedge clk);
        chk("awready_after_b", 64'(axi4_awready), 64'(1));
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] id);
        bit legal;
        int n;
        legal = !burst[1];
        for (int i = 0; i <= int'(len); i++) begin
            rexp_t r;
            r.d = legal ? rd_fn(beat_addr(addr, burst, i)) : 32'h0;
            r.resp = legal ? 2'b00 : 2'b10;
            r.last = (i == int'(len));
            r.id = id;
            exp_r.push_back(r);
            if (legal) exp_rad.push_back(beat_addr(addr, burst, i));
        end
        @(posedge clk); #1;
        axi4_arvalid = 1'b1; axi4_araddr = addr; axi4_arlen = len;
        axi4_arburst = burst; axi4_arid = id; axi4_arsize = 3'($urandom_range(0, 7));
        n = 0;
        forever begin
            @(negedge clk);
            if (axi4_arready) break;
            n++;
            if (n > 500) begin fail("ar_timeout"); break; end
        end
        @(posedge clk); #1;
        axi4_arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0] id);
        int n;
        ar_issue(addr, len, burst, id);
        n = 0;
        forever begin
            @(posedge clk);
            if (exp_r.size() == 0) break;
            n++;
            if (n > 3000) begin fail("r_timeout"); exp_r.delete(); exp_rad.delete(); break; end
        end
        chk("rad_all_issued", 64'(exp_rad.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        axi4_awvalid = 1'b0; axi4_awaddr = '0; axi4_awlen = '0; axi4_awburst = '0;
        axi4_awsize = '0; axi4_awid = '0;
        axi4_wvalid = 1'b0; axi4_wdata = '0; axi4_wstrb = '0; axi4_wlast = 1'b0;
        axi4_bready = 1'b1;
        axi4_arvalid = 1'b0; axi4_araddr = '0; axi4_arlen = '0; axi4_arburst = '0;
        axi4_arsize = '0; axi4_arid = '0;
        axi4_rready = 1'b1;
        mem_wreq_rdy = 1'b1; mem_rreq_rdy = 1'b1; mem_rdat = '0; mem_rdat_vld = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", 64'(|{axi4_awready, axi4_wready, axi4_bvalid, axi4_bresp, axi4_bid,
            axi4_arready, axi4_rvalid, axi4_rdata, axi4_rresp, axi4_rlast, axi4_rid,
            mem_bwe, mem_wad, mem_wdat, mem_re, mem_rad}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'({axi4_awready, axi4_arready}), 64'(2'b11));

        // single-beat write
        do_write(32'h100, 8'd0, INCR, 8'd5, 1, 32'hDEADBEEF, 1'b0);
        // INCR read, latency 3
        lat = 3;
        do_read(32'h200, 8'd7, INCR, 8'h21);
        // read backpressure: rready low for 20 cycles
        rready_hold = cyc + 20;
        do_read(32'h300, 8'd15, INCR, 8'h03);
        // FIXED write with toggling memory ready
        wrdy_mode = 2; chk_mirror = 1'b1;
        do_write(32'h40, 8'd3, FIXED, 8'd7, 4, 32'h1000, 1'b0);
        chk_mirror = 1'b0; wrdy_mode = 0;
        // WRAP and reserved bursts
        do_read(32'h500, 8'd3, WRAP, 8'd4);
        do_read(32'h540, 8'd1, RSVD, 8'd6);
        do_write(32'h580, 8'd2, WRAP, 8'd8, 3, 32'h77, 1'b0);
        // early and late wlast
        do_write(32'h600, 8'd3, INCR, 8'd2, 2, 32'hA0, 1'b0);
        do_write(32'h700, 8'd1, INCR, 8'd9, 3, 32'hB0, 1'b0);
        // address wraps modulo 2^AW
        do_read(32'hFFFF_FFF8, 8'd3, INCR, 8'd1);

        // reset in the middle of a read burst
        rready_hold = cyc + 1000; lat = 2;
        ar_issue(32'h800, 8'd15, INCR, 8'd9);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_r.delete(); exp_rad.delete();
        @(negedge clk);
        chk("midburst_reset_outputs_zero", 64'(|{axi4_awready, axi4_wready, axi4_bvalid, axi4_bresp,
            axi4_bid, axi4_arready, axi4_rvalid, axi4_rdata, axi4_rresp, axi4_rlast, axi4_rid,
            mem_bwe, mem_wad, mem_wdat, mem_re, mem_rad}), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rready_hold = 0;
        @(negedge clk);
        chk("ready_after_midburst_reset", 64'({axi4_awready, axi4_arready}), 64'(2'b11));

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  b;
            logic [7:0]  len;
            logic [31:0] addr;
            int          nb;
            wrdy_mode = $urandom_range(0, 2); rrdy_mode = $urandom_range(0, 1);
            rready_mode = $urandom_range(0, 1); bready_mode = $urandom_range(0, 1);
            lat = $urandom_range(1, 6);
            b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            len = 8'($urandom_range(0, 15));
            addr = $urandom & 32'hFFFF_FFFC;
            nb = int'(len) + 1;
            if ($urandom_range(0, 5) == 0) nb = (nb > 1 && $urandom_range(0, 1) == 1) ? nb - 1 : nb + 1;
            case ($urandom_range(0, 2))
                0: do_write(addr, len, b, 8'(k), nb, 32'h0, 1'b1);
                1: do_read(addr, len, b, 8'(k));
                default: fork
                    do_write(addr, len, b, 8'(k), nb, 32'h0, 1'b1);
                    do_read(addr ^ 32'h0001_0000, len, b, 8'(k + 100));
                join
            endcase
        end

        repeat (5) @(posedge clk);
        chk("exp_w_drained", 64'(exp_w.size()), 64'(0));
        chk("exp_r_drained", 64'(exp_r.size()), 64'(0));
        chk("exp_b_drained", 64'(exp_b.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
